// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer: FSM state encodings, reset-cause
// codes and a small constant helper used to size counters.
// No ports.
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_ASSERT  = 2'd0;
    localparam state_t ST_RELEASE = 2'd1;
    localparam state_t ST_RUN     = 2'd2;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR  = 2'b00;
    localparam cause_t CAUSE_SW   = 2'b01;
    localparam cause_t CAUSE_EXT  = 2'b10;
    localparam cause_t CAUSE_WDOG = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl_if
// Request/status bundle of the reset sequencer.
//   sw_rst_req  : software reset request (level)
//   ext_rst_req : external/PS reset request (level, already synchronised)
//   wdog_kick   : watchdog service pulse
//   dom_rst     : per-domain active-high resets, bit 0 released first
//   rst_busy    : high while the sequencer is not in RUN
//   seq_done    : one-cycle pulse when a sequence completes
//   rst_cause   : cause of the last sequence (POR/SW/EXT/WDOG)
// master: the requester / consumer side; slave: the sequencer.
// ---------------------------------------------------------------------------
interface rst_seq_ctrl_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM = 4
);

    logic               sw_rst_req;
    logic               ext_rst_req;
    logic               wdog_kick;
    logic [NUM_DOM-1:0] dom_rst;
    logic               rst_busy;
    logic               seq_done;
    cause_t             rst_cause;

    modport master (
        output sw_rst_req, ext_rst_req, wdog_kick,
        input  dom_rst, rst_busy, seq_done, rst_cause
    );

    modport slave (
        input  sw_rst_req, ext_rst_req, wdog_kick,
        output dom_rst, rst_busy, seq_done, rst_cause
    );

endinterface

// File: rtl/rst_seq_wdog.sv
// ---------------------------------------------------------------------------
// rst_seq_wdog
// Watchdog counter for the reset sequencer. Counts only while the sequencer
// is in RUN, clears on a kick, outside RUN and on reset. wdog_expire is high
// while the count sits at WDOG_TIMEOUT-1 with no kick in the same cycle, so a
// kick on the timeout cycle suppresses the reset.
// Only present when RST_SEQ_WDOG_EN is defined.
//   clk_in      : clock
//   rst_in      : synchronous active-high reset
//   run_i       : sequencer is in RUN
//   kick_i      : watchdog service pulse
//   wdog_expire : timeout request to the sequencer
// ---------------------------------------------------------------------------
`ifdef RST_SEQ_WDOG_EN
module rst_seq_wdog #(
    parameter int WDOG_TIMEOUT = 1000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run_i,
    input  logic kick_i,
    output logic wdog_expire
);

    localparam int                WD_W    = $clog2(WDOG_TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q;
    logic            at_last;

    assign at_last     = (cnt_q == WD_LAST);
    assign wdog_expire = run_i && at_last && !kick_i;

    always_ff @(posedge clk_in) begin
        if (rst_in || !run_i || kick_i) begin
            cnt_q <= '0;
        end else if (!at_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
// Staged per-domain reset sequencer. All domains are asserted together, held
// for HOLD_CYC cycles, then released one at a time in index order, GAP_CYC
// cycles apart. Runtime requests (EXT > WDOG > SW) restart the sequence from
// RUN; EXT also restarts it from RELEASE and stretches the hold in ASSERT.
// Optional watchdog: define RST_SEQ_WDOG_EN to instantiate rst_seq_wdog.
//   clk_in : clock (single domain)
//   rst_in : synchronous active-high reset
//   bus    : rst_seq_ctrl_if.slave request/status bundle
// All outputs are registered.
// ---------------------------------------------------------------------------
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOM      = 4,
    parameter int HOLD_CYC     = 16,
    parameter int GAP_CYC      = 4,
    parameter int WDOG_TIMEOUT = 1000000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    rst_seq_ctrl_if.slave bus
);

    localparam int               CNT_W     = $clog2(max_int(HOLD_CYC, GAP_CYC) + 1);
    localparam int               IDX_W     = $clog2(NUM_DOM) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;     // hold count in ASSERT, gap count in RELEASE
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    cause_t             cause_q,   cause_d;
    logic               wdog_expire;

`ifdef RST_SEQ_WDOG_EN
    rst_seq_wdog #(
        .WDOG_TIMEOUT (WDOG_TIMEOUT)
    ) u_wdog (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .run_i       (state_q == ST_RUN),
        .kick_i      (bus.wdog_kick),
        .wdog_expire (wdog_expire)
    );
`else
    logic unused_wdog;
    assign wdog_expire = 1'b0;
    // The kick input and timeout value have no function without the watchdog.
    assign unused_wdog = bus.wdog_kick | (WDOG_TIMEOUT == 0);
`endif

    // NOTE: every next-state signal takes its current value first, so no path
    // through the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cause_d   = cause_q;

        case (state_q)
            ST_ASSERT: begin
                dom_rst_d = '1;
                busy_d    = 1'b1;
                if (bus.ext_rst_req) begin
                    cnt_d = '0;          // EXT held keeps the hold window open
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (bus.ext_rst_req) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    dom_rst_d = '1;
                    cause_d   = CAUSE_EXT;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    dom_rst_d = dom_rst_q & ~(NUM_DOM'(1) << idx_q);
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                dom_rst_d = '0;
                if (bus.ext_rst_req || wdog_expire || bus.sw_rst_req) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    dom_rst_d = '1;
                    busy_d    = 1'b1;
                    if (bus.ext_rst_req) begin
                        cause_d = CAUSE_EXT;
                    end else if (wdog_expire) begin
                        cause_d = CAUSE_WDOG;
                    end else begin
                        cause_d = CAUSE_SW;
                    end
                end
            end

            default: begin
                // Unused encoding: recover by restarting the sequence.
                state_d   = ST_ASSERT;
                cnt_d     = '0;
                idx_d     = '0;
                dom_rst_d = '1;
                busy_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the reset is synchronous and checked inside the block.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            dom_rst_q <= '1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_POR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dom_rst_q <= dom_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.dom_rst   = dom_rst_q;
    assign bus.rst_busy  = busy_q;
    assign bus.seq_done  = done_q;
    assign bus.rst_cause = cause_q;

endmodule
